btn_dir_ctrl: RTL

BTN_DIR_CTRL -- requirements
Module: btn_dir_ctrl

---
 rtl/btn_dir_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/btn_dir_ctrl.sv
// Four-button direction controller: synchronise, debounce and edge-detect each
// button, then hold one pending request and commit it on the next game tick.
module btn_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [1:0]  DIR_RESET       = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_t,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic [3:0] btn_level,
  output logic [7:0] commit_cnt
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  raw;
  logic [3:0]  sync_a;
  logic [3:0]  sync_b;
  logic [3:0]  level;
  logic [3:0]  level_d;
  logic [3:0]  press;
  logic [19:0] cnt [4];

  logic        sel_valid;
  dir_t        sel_dir;
  logic        pend_valid;
  dir_t        pend_dir;
  dir_t        dir_q;

  // Bit order matches btn_level: {r, l, d, t}, i.e. bit index == direction code.
  assign raw = {btn_r, btn_l, btn_d, btn_t};

  function automatic dir_t reverse_of(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      press   <= level & ~level_d;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync_b[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= sync_b[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  always_comb begin
    sel_valid = |press;
    sel_dir   = DIR_RIGHT;
    if (press[0]) begin
      sel_dir = DIR_UP;
    end else if (press[1]) begin
      sel_dir = DIR_DOWN;
    end else if (press[2]) begin
      sel_dir = DIR_LEFT;
    end
  end

  // The tick consumes the old pending value; a same-cycle press is written
  // afterwards so it survives as the new pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q       <= dir_t'(DIR_RESET);
      dir_changed <= 1'b0;
      commit_cnt  <= '0;
      pend_valid  <= 1'b0;
      pend_dir    <= DIR_UP;
    end else begin
      dir_changed <= 1'b0;
      if (tick && pend_valid) begin
        pend_valid <= 1'b0;
        if (pend_dir != dir_q && pend_dir != reverse_of(dir_q)) begin
          dir_q       <= pend_dir;
          dir_changed <= 1'b1;
          commit_cnt  <= commit_cnt + 8'd1;
        end
      end
      if (sel_valid) begin
        pend_valid <= 1'b1;
        pend_dir   <= sel_dir;
      end
    end
  end

  assign dir       = dir_q;
  assign btn_level = level;

endmodule
